// File: rtl/controller_tc_reset_pulser_if.sv
// Register bus between a host and the reset pulser.
// The master drives the address and write strobes; the slave returns zero-wait-state read data.
interface controller_tc_reset_pulser_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/controller_tc_reset_pulser.sv
// Reset-line controller: per-channel level bits plus retriggerable fixed-length pulses.
// Every output is registered from next-state values, so bus writes show on the following cycle.
module controller_tc_reset_pulser #(
    parameter int               WIDTH   = 4,
    parameter int               CNT_W   = 16,
    parameter int               DEF_LEN = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    controller_tc_reset_pulser_if.slave  bus,
    output logic [WIDTH-1:0]             out_port,
    output logic                         busy
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_SET    = 3'd1;
    localparam logic [2:0] A_CLR    = 3'd2;
    localparam logic [2:0] A_LEN    = 3'd3;
    localparam logic [2:0] A_PULSE  = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PULSING = 1'b1
    } chan_state_t;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [CNT_W-1:0] w_wd_len;
    logic [CNT_W-1:0] w_load_len;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_next;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_next;
    logic [WIDTH-1:0] r_out;
    logic             r_busy;

    logic [WIDTH-1:0] w_pulse_mask;
    logic [WIDTH-1:0] w_clr_mask;
    logic [WIDTH-1:0] w_active;
    logic [WIDTH-1:0] w_active_next;
    logic [31:0]      w_rdata;

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_wd           = bus.writedata[WIDTH-1:0];
    assign w_wd_len       = bus.writedata[CNT_W-1:0];
    assign w_unused_wdata = ^bus.writedata;

    // A zero length still produces a single-cycle pulse.
    assign w_load_len = (r_len == '0) ? CNT_W'(1) : r_len;

    always_comb begin
        w_data_next  = r_data;
        w_len_next   = r_len;
        w_pulse_mask = '0;
        w_clr_mask   = '0;
        if (w_wr) begin
            case (bus.address)
                A_DATA:  w_data_next = w_wd;
                A_SET:   w_data_next = r_data | w_wd;
                A_CLR: begin
                    w_data_next = r_data & ~w_wd;
                    w_clr_mask  = w_wd;
                end
                A_LEN:   w_len_next   = w_wd_len;
                A_PULSE: w_pulse_mask = w_wd;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RST_VAL;
            r_len  <= CNT_W'(DEF_LEN);
            r_out  <= RST_VAL;
            r_busy <= 1'b0;
        end else begin
            r_data <= w_data_next;
            r_len  <= w_len_next;
            r_out  <= w_data_next | w_active_next;
            r_busy <= |w_active_next;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            chan_state_t      r_state;
            chan_state_t      w_state_next;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                end
            end

            // Priority: clear beats a (re)trigger, which beats normal countdown/expiry.
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                if (r_state == S_PULSING) begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                if (w_pulse_mask[gi]) begin
                    w_state_next = S_PULSING;
                    w_cnt_next   = w_load_len;
                end
                if (w_clr_mask[gi]) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            end

            assign w_active[gi]      = (r_state == S_PULSING);
            assign w_active_next[gi] = (w_state_next == S_PULSING);
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            A_DATA:   w_rdata[WIDTH-1:0] = r_data;
            A_LEN:    w_rdata[CNT_W-1:0] = r_len;
            A_PULSE:  w_rdata[WIDTH-1:0] = w_active;
            A_STATUS: w_rdata[0]         = r_busy;
            default:  ;
        endcase
    end

    assign bus.readdata = w_rdata;
    assign out_port     = r_out;
    assign busy         = r_busy;

endmodule

// File: tb/tb_controller_tc_reset_pulser.sv
// Bench for controller_tc_reset_pulser: directed scenarios plus random bus traffic,
// checked against a model that tracks each channel's pulse as an absolute end cycle.
module tb_controller_tc_reset_pulser;

    logic       clk;
    logic       reset_n;
    logic [3:0] out_port;
    logic       busy;

    controller_tc_reset_pulser_if bus ();

    controller_tc_reset_pulser #(
        .WIDTH   (4),
        .CNT_W   (16),
        .DEF_LEN (16),
        .RST_VAL (4'h0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycle number advances on each rising edge; channel i is active while cyc < m_end[i].
    int         cyc;
    logic [3:0] m_data;
    int         m_len;
    int         m_end [4];

    function automatic logic [3:0] m_active();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (cyc < m_end[i]);
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a)
            3'd0: r[3:0]  = m_data;
            3'd3: r[15:0] = m_len[15:0];
            3'd4: r[3:0]  = m_active();
            3'd5: r[0]    = |m_active();
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic m_reset();
        m_data = 4'h0;
        m_len  = 16;
        for (int i = 0; i < 4; i++) m_end[i] = 0;
    endtask

    task automatic m_write(input logic [2:0] a, input logic [31:0] d);
        int plen;
        plen = (m_len == 0) ? 1 : m_len;
        case (a)
            3'd0: m_data = d[3:0];
            3'd1: m_data = m_data | d[3:0];
            3'd2: begin
                m_data = m_data & ~d[3:0];
                for (int i = 0; i < 4; i++) if (d[i]) m_end[i] = cyc;
            end
            3'd3: m_len = int'(d[15:0]);
            3'd4: for (int i = 0; i < 4; i++) if (d[i]) m_end[i] = cyc + plen;
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: present the bus, take the edge, update the model, then check the outputs.
    task automatic tick(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = d;
        @(posedge clk);
        cyc++;
        if (cs && !wn) m_write(a, d);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        chk("out_port", {28'h0, out_port}, {28'h0, m_data | m_active()});
        chk("busy", {31'h0, busy}, {31'h0, |m_active()});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        tick(1'b1, 1'b0, a, d);
        $display("cyc %0d WR addr=%0d data=0x%08h out_port=0x%0h busy=%0b", cyc, a, d, out_port, busy);
    endtask

    task automatic idle();
        tick(1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic rd(input logic [2:0] a, input string tag);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        #1;
        chk(tag, bus.readdata, m_read(a));
        $display("cyc %0d RD addr=%0d data=0x%08h", cyc, a, bus.readdata);
        tick(1'b1, 1'b1, a, 32'h0);
    endtask

    logic [2:0]  ra;
    logic [31:0] rdat;
    int          rk;

    initial begin
        cyc            = 0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        reset_n        = 1'b0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_out_port", {28'h0, out_port}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        reset_n = 1'b1;

        // Defaults on all eight addresses.
        for (int i = 0; i < 8; i++) rd(3'(i), "reset_read");

        // Level register with clear.
        wr(3'd0, 32'h0000_000F);
        wr(3'd2, 32'h0000_0005);
        rd(3'd0, "data_after_clr");
        chk("clr_out_port", {28'h0, out_port}, 32'hA);
        wr(3'd1, 32'hFFFF_FFF0);
        rd(3'd1, "set_reads_zero");
        wr(3'd0, 32'h0);

        // Basic 3-cycle pulse.
        wr(3'd3, 32'd3);
        rd(3'd3, "len_readback");
        wr(3'd4, 32'h2);
        rd(3'd4, "pulse_mask");
        rd(3'd5, "status_busy");
        repeat (4) idle();

        // Retrigger mid-pulse: 6 continuous cycles.
        wr(3'd3, 32'd4);
        wr(3'd4, 32'h1);
        idle();
        wr(3'd4, 32'h1);
        repeat (7) idle();

        // Retrigger exactly on the expiry cycle.
        wr(3'd3, 32'd2);
        wr(3'd4, 32'h1);
        idle();
        wr(3'd4, 32'h1);
        repeat (3) idle();

        // Zero length behaves as one; CLR cancels a long pulse.
        wr(3'd3, 32'd0);
        wr(3'd4, 32'h8);
        repeat (2) idle();
        wr(3'd3, 32'd10);
        wr(3'd4, 32'h8);
        repeat (2) idle();
        wr(3'd2, 32'h8);
        repeat (2) idle();

        // Read-only and unmapped addresses ignore writes.
        wr(3'd5, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        for (int i = 5; i < 8; i++) rd(3'(i), "ignored_read");
        rd(3'd0, "data_untouched");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rk   = int'($urandom_range(0, 9));
            ra   = 3'($urandom_range(0, 7));
            rdat = $urandom;
            if (rk < 3) begin
                idle();
            end else if (rk < 5) begin
                rd(ra, "rand_read");
            end else begin
                if (ra == 3'd3) rdat = (rdat & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
                if (ra == 3'd0 || ra == 3'd1) rdat = rdat & 32'hFFFF_FFF3;
                wr(ra, rdat);
            end
        end

        // Asynchronous reset in the middle of a long pulse.
        wr(3'd0, 32'h0);
        wr(3'd3, 32'd100);
        wr(3'd4, 32'hF);
        repeat (4) idle();
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst_out_port", {28'h0, out_port}, 32'h0);
        chk("async_rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(3'd3, "len_after_reset");
        rd(3'd4, "mask_after_reset");
        repeat (110) idle();
        wr(3'd0, 32'h3);
        rd(3'd0, "first_write_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
